time_set_control: RTL and testbench



---
 rtl/clock_pkg.sv | 37 +++
 rtl/repeat_gen.sv | 90 +++++++++
 rtl/time_set_control.sv | 153 +++++++++++++++
 tb/tb_time_set_control.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the digital clock: set-mode encodings, the default
// millisecond timing constants used by count_ms and time_set_control, and a
// helper that steps the MODE button through the editable fields.
// -----------------------------------------------------------------------------
package clock_pkg;

    // Which field the front panel is editing.
    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_t;

    // System clock and the divider count_ms uses to produce ms_tick.
    localparam int unsigned CLK_HZ       = 50_000_000;
    localparam int unsigned CLKS_PER_MS  = CLK_HZ / 1000;

    // Front-panel timing, all in milliseconds (ms_tick periods).
    localparam int unsigned DEF_REPEAT_DELAY_MS = 500;
    localparam int unsigned DEF_REPEAT_RATE_MS  = 200;
    localparam int unsigned DEF_BLINK_HALF_MS   = 500;
    localparam int unsigned DEF_TIMEOUT_MS      = 10000;

    // MODE press order: RUN -> HOUR -> MIN -> SEC -> RUN.
    function automatic mode_t next_field(input mode_t m);
        case (m)
            MODE_RUN:      return MODE_SET_HOUR;
            MODE_SET_HOUR: return MODE_SET_MIN;
            MODE_SET_MIN:  return MODE_SET_SEC;
            default:       return MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/repeat_gen.sv
// -----------------------------------------------------------------------------
// repeat_gen
// Press detection and press-and-hold auto-repeat for one debounced button.
// A press edge gives one pulse; holding the button gives a further pulse after
// REPEAT_DELAY_MS ticks and then one every REPEAT_RATE_MS ticks.
//
// Ports:
//   ck       in   system clock
//   rst      in   synchronous active-high reset
//   ms_tick  in   1 ms tick pulse
//   btn      in   debounced button level
//   enable   in   repeat allowed (a SET mode is active)
//   freeze   in   cancel the current hold; needs a fresh press to re-arm
//   pulse    out  registered one-cycle command pulse
//   fire     out  next-cycle value of pulse (lets the parent react in step)
// -----------------------------------------------------------------------------
module repeat_gen
    import clock_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
    parameter int unsigned REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS
) (
    input  logic ck,
    input  logic rst,
    input  logic ms_tick,
    input  logic btn,
    input  logic enable,
    input  logic freeze,
    output logic pulse,
    output logic fire
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ?
                                      REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_MS - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_MS - 1);

    logic             prev;
    logic             armed;      // an accepted press is still being held
    logic             repeating;  // first delay done, now on the rate interval
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic             press;
    logic             hold_ok;
    logic             period_done;

    assign press       = btn & ~prev;
    assign hold_ok     = btn & enable & ~freeze;
    assign last        = repeating ? RATE_LAST : DELAY_LAST;
    assign period_done = armed & ms_tick & (cnt == last);
    // armed is always clear on a press edge (it drops when btn goes low), so
    // the two terms below never overlap.
    assign fire        = hold_ok & (press | period_done);

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge ck) begin
        // NOTE: prev is loaded (not cleared) during reset so a button held
        // through reset is not seen as a press when reset releases.
        prev <= btn;
        if (rst) begin
            armed     <= 1'b0;
            repeating <= 1'b0;
            cnt       <= '0;
            pulse     <= 1'b0;
        end else begin
            pulse <= fire;
            if (!hold_ok) begin
                // Released, disabled or frozen: drop the hold immediately.
                armed     <= 1'b0;
                repeating <= 1'b0;
                cnt       <= '0;
            end else if (press) begin
                // A tick coinciding with the press is not counted.
                armed     <= 1'b1;
                repeating <= 1'b0;
                cnt       <= '0;
            end else if (armed && ms_tick) begin
                if (cnt == last) begin
                    cnt       <= '0;
                    repeating <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/time_set_control.sv
// -----------------------------------------------------------------------------
// time_set_control
// Front-panel controller of the digital clock. MODE steps through the editable
// fields, UP/DOWN produce increment/decrement pulses with auto-repeat, the
// field being edited blinks, and inactivity drops back to RUN.
//
// Ports:
//   ck          in   system clock
//   rst         in   synchronous active-high reset
//   ms_tick     in   1 ms tick pulse from count_ms
//   btn_mode    in   debounced MODE level
//   btn_up      in   debounced UP level
//   btn_down    in   debounced DOWN level
//   mode [1:0]  out  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC
//   set_active  out  high whenever mode is not RUN
//   inc_pulse   out  one-cycle increment of the selected field
//   dec_pulse   out  one-cycle decrement of the selected field
//   blink       out  blank enable for the selected field
// -----------------------------------------------------------------------------
module time_set_control
    import clock_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY_MS = DEF_REPEAT_DELAY_MS,
    parameter int unsigned REPEAT_RATE_MS  = DEF_REPEAT_RATE_MS,
    parameter int unsigned BLINK_HALF_MS   = DEF_BLINK_HALF_MS,
    parameter int unsigned TIMEOUT_MS      = DEF_TIMEOUT_MS
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       ms_tick,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] mode,
    output logic       set_active,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic       blink
);

    localparam int TO_W = $clog2(TIMEOUT_MS + 1);
    localparam int BL_W = $clog2(BLINK_HALF_MS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_MS - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_HALF_MS - 1);

    mode_t           mode_q;
    mode_t           mode_d;
    logic            mode_prev;
    logic            mode_edge;
    logic            activity;
    logic            to_fire;
    logic [TO_W-1:0] to_cnt;
    logic [BL_W-1:0] bl_cnt;
    logic            both;
    logic            freeze;
    logic            enable;
    logic            up_fire;
    logic            down_fire;

    assign mode_edge = btn_mode & ~mode_prev;
    // Any held level counts as activity, which also covers every press edge.
    assign activity  = btn_mode | btn_up | btn_down;
    assign to_fire   = (mode_q != MODE_RUN) & ~activity & ms_tick &
                       (to_cnt == TO_LAST);

    // ---------------- mode FSM ----------------
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        mode_d = mode_q;
        if (to_fire)
            mode_d = MODE_RUN;               // timeout beats a MODE edge
        else if (mode_edge)
            mode_d = next_field(mode_q);
    end

    always_ff @(posedge ck) begin
        mode_prev <= btn_mode;
        if (rst) begin
            mode_q     <= MODE_RUN;
            set_active <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            set_active <= (mode_d != MODE_RUN);
        end
    end

    assign mode = mode_q;

    // ---------------- inactivity timeout ----------------
    always_ff @(posedge ck) begin
        if (rst || mode_q == MODE_RUN || activity)
            to_cnt <= '0;
        else if (ms_tick)
            to_cnt <= to_fire ? '0 : to_cnt + 1'b1;
    end

    // ---------------- UP / DOWN ----------------
    // Both buttons down, or a MODE edge, cancels any hold; each button then
    // has to be released and pressed again before it acts.
    assign both   = btn_up & btn_down;
    assign freeze = mode_edge | both;
    assign enable = (mode_q != MODE_RUN);

    repeat_gen #(
        .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
        .REPEAT_RATE_MS  (REPEAT_RATE_MS)
    ) u_up (
        .ck      (ck),
        .rst     (rst),
        .ms_tick (ms_tick),
        .btn     (btn_up),
        .enable  (enable),
        .freeze  (freeze),
        .pulse   (inc_pulse),
        .fire    (up_fire)
    );

    repeat_gen #(
        .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
        .REPEAT_RATE_MS  (REPEAT_RATE_MS)
    ) u_down (
        .ck      (ck),
        .rst     (rst),
        .ms_tick (ms_tick),
        .btn     (btn_down),
        .enable  (enable),
        .freeze  (freeze),
        .pulse   (dec_pulse),
        .fire    (down_fire)
    );

    // ---------------- blink ----------------
    // Restarted in the same cycle a pulse or mode change is registered, so an
    // edited value is shown (not blanked) as soon as it changes.
    always_ff @(posedge ck) begin
        if (rst || mode_d == MODE_RUN) begin
            bl_cnt <= '0;
            blink  <= 1'b0;
        end else if (mode_d != mode_q || up_fire || down_fire) begin
            bl_cnt <= '0;
            blink  <= 1'b0;
        end else if (ms_tick) begin
            if (bl_cnt == BL_LAST) begin
                bl_cnt <= '0;
                blink  <= ~blink;
            end else begin
                bl_cnt <= bl_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_time_set_control.sv
module tb_time_set_control;

    localparam int D = 500;
    localparam int R = 200;
    localparam int H = 500;
    localparam int T = 10000;

    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic       ms_tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [1:0] mode;
    logic       set_active;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       blink;

    time_set_control #(
        .REPEAT_DELAY_MS (D),
        .REPEAT_RATE_MS  (R),
        .BLINK_HALF_MS   (H),
        .TIMEOUT_MS      (T)
    ) dut (
        .ck         (ck),
        .rst        (rst),
        .ms_tick    (ms_tick),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .mode       (mode),
        .set_active (set_active),
        .inc_pulse  (inc_pulse),
        .dec_pulse  (dec_pulse),
        .blink      (blink)
    );

    always #5 ck = ~ck;

    int    n_vec  = 0;
    int    n_miss = 0;
    string phase  = "init";

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, $time, got, got, exp, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks whole-hold tick counts and elapsed ticks since the last restart,
    // deriving pulses and blink phase arithmetically from those totals.
    int m_mode;
    bit pm, pu, pd;
    bit arm_u, arm_d;
    int hold_u, hold_d;
    int idle;
    int bt;
    bit e_inc, e_dec, e_blink;

    task automatic model_btn(input bit b, input bit press, input bit kill, input bit t,
                             inout bit arm, inout int hold, output bit pulse);
        pulse = 1'b0;
        if (!b || kill) begin
            arm = 1'b0;
        end else if (press) begin
            arm = 1'b1; hold = 0; pulse = 1'b1;
        end else if (arm && t) begin
            hold++;
            if (hold == D || (hold > D && (hold - D) % R == 0)) pulse = 1'b1;
        end
    endtask

    task automatic model(input bit r, input bit m, input bit u, input bit d, input bit t);
        bit mp, up_p, dn_p, kill, to_hit, inc, dec;
        int nm;
        if (r) begin
            m_mode = 0; arm_u = 0; arm_d = 0; hold_u = 0; hold_d = 0;
            idle = 0; bt = 0; e_inc = 0; e_dec = 0; e_blink = 0;
        end else begin
            mp = m & !pm; up_p = u & !pu; dn_p = d & !pd;
            to_hit = 0;
            if (m_mode == 0 || m || u || d) idle = 0;
            else if (t) begin
                idle++;
                if (idle == T) begin to_hit = 1; idle = 0; end
            end
            nm = to_hit ? 0 : (mp ? (m_mode + 1) % 4 : m_mode);
            kill = mp || (u && d) || (m_mode == 0);
            model_btn(u, up_p, kill, t, arm_u, hold_u, inc);
            model_btn(d, dn_p, kill, t, arm_d, hold_d, dec);
            if (nm == 0 || nm != m_mode || inc || dec) begin
                bt = 0; e_blink = 0;
            end else if (t) begin
                bt++;
                e_blink = ((bt / H) % 2) == 1;
            end
            m_mode = nm; e_inc = inc; e_dec = dec;
        end
        pm = m; pu = u; pd = d;
    endtask

    function automatic int dut_word();
        return {26'd0, mode, set_active, inc_pulse, dec_pulse, blink};
    endfunction

    function automatic int pack(input int md, input bit sa, input bit i, input bit dc, input bit bl);
        return (md << 4) | (int'(sa) << 3) | (int'(i) << 2) | (int'(dc) << 1) | int'(bl);
    endfunction

    // One clock: drive, clock, advance model, optionally compare with model.
    task automatic step(input bit r, input bit m, input bit u, input bit d,
                        input bit t, input bit cmp);
        rst = r; btn_mode = m; btn_up = u; btn_down = d; ms_tick = t;
        @(posedge ck);
        #1;
        model(r, m, u, d, t);
        if (cmp) check(phase, dut_word(), pack(m_mode, m_mode != 0, e_inc, e_dec, e_blink));
    endtask

    task automatic press_mode();
        step(0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
    endtask

    typedef struct {
        bit rst; bit bm; bit bu; bit bd; bit tk;
        int md;  bit sa; bit inc; bit dec; bit blk;
    } vec_t;

    vec_t tbl[24];

    initial begin
        int n_inc, n_dec, first;
        int rep_at[$];
        bit ru, rd, rm;

        tbl[0]  = '{1,1,0,0,0, 0,0,0,0,0};  // MODE held through reset
        tbl[1]  = '{0,1,0,0,0, 0,0,0,0,0};  // no edge on reset release
        tbl[2]  = '{0,0,0,0,0, 0,0,0,0,0};
        tbl[3]  = '{0,1,0,0,0, 1,1,0,0,0};
        tbl[4]  = '{0,0,0,0,0, 1,1,0,0,0};
        tbl[5]  = '{0,1,0,0,0, 2,1,0,0,0};
        tbl[6]  = '{0,0,0,0,0, 2,1,0,0,0};
        tbl[7]  = '{0,1,0,0,0, 3,1,0,0,0};
        tbl[8]  = '{0,0,0,0,0, 3,1,0,0,0};
        tbl[9]  = '{0,1,1,0,0, 0,0,0,0,0};  // MODE+UP same cycle in SET_SEC
        tbl[10] = '{0,0,0,0,0, 0,0,0,0,0};
        tbl[11] = '{0,0,1,1,0, 0,0,0,0,0};  // UP+DOWN in RUN
        tbl[12] = '{0,0,0,0,0, 0,0,0,0,0};
        tbl[13] = '{0,1,0,0,0, 1,1,0,0,0};
        tbl[14] = '{0,0,0,0,0, 1,1,0,0,0};
        tbl[15] = '{0,0,1,0,0, 1,1,1,0,0};  // UP press
        tbl[16] = '{0,0,1,0,1, 1,1,0,0,0};
        tbl[17] = '{0,0,1,1,0, 1,1,0,0,0};  // DOWN joins: suppressed
        tbl[18] = '{0,0,1,0,0, 1,1,0,0,0};  // DOWN released: no new press
        tbl[19] = '{0,0,0,0,0, 1,1,0,0,0};
        tbl[20] = '{0,0,1,0,0, 1,1,1,0,0};
        tbl[21] = '{0,0,0,0,0, 1,1,0,0,0};
        tbl[22] = '{0,0,0,1,0, 1,1,0,1,0};
        tbl[23] = '{0,0,0,0,0, 1,1,0,0,0};

        for (int i = 0; i < 24; i++) begin
            step(tbl[i].rst, tbl[i].bm, tbl[i].bu, tbl[i].bd, tbl[i].tk, 0);
            check($sformatf("table[%0d]", i), dut_word(),
                  pack(tbl[i].md, tbl[i].sa, tbl[i].inc, tbl[i].dec, tbl[i].blk));
        end

        // ---- auto-repeat in SET_MIN ----
        phase = "repeat";
        press_mode();                       // 1 -> 2
        check("repeat_mode", int'(mode), 2);
        n_inc = 0; n_dec = 0;
        step(0, 0, 1, 0, 0, 1);
        check("repeat_first_pulse", int'(inc_pulse), 1);
        n_inc += int'(inc_pulse);
        for (int k = 1; k <= 1200; k++) begin
            step(0, 0, 1, 0, 0, 1);
            n_inc += int'(inc_pulse); n_dec += int'(dec_pulse);
            step(0, 0, 1, 0, 1, 1);
            n_inc += int'(inc_pulse); n_dec += int'(dec_pulse);
            if (inc_pulse) rep_at.push_back(k);
        end
        step(0, 0, 0, 0, 0, 1);
        check("repeat_inc_total", n_inc, 5);
        check("repeat_dec_total", n_dec, 0);
        check("repeat_count", rep_at.size(), 4);
        for (int i = 0; i < rep_at.size() && i < 4; i++)
            check($sformatf("repeat_tick[%0d]", i), rep_at[i], D + R * i);

        // ---- both buttons in SET_HOUR ----
        phase = "both";
        press_mode(); press_mode(); press_mode();   // 2 -> 3 -> 0 -> 1
        check("both_mode", int'(mode), 1);
        n_inc = 0; n_dec = 0;
        step(0, 0, 1, 0, 0, 1);
        n_inc += int'(inc_pulse);
        for (int k = 0; k < 100; k++) begin
            step(0, 0, 1, 0, 1, 1);
            n_inc += int'(inc_pulse); n_dec += int'(dec_pulse);
        end
        step(0, 0, 1, 1, 0, 1);
        n_inc += int'(inc_pulse); n_dec += int'(dec_pulse);
        for (int k = 0; k < 1000; k++) begin
            step(0, 0, 1, 1, 1, 1);
            n_inc += int'(inc_pulse); n_dec += int'(dec_pulse);
        end
        check("both_inc", n_inc, 1);
        check("both_dec", n_dec, 0);
        n_inc = 0;
        for (int k = 0; k < 600; k++) begin
            step(0, 0, 1, 0, 1, 1);
            n_inc += int'(inc_pulse) + int'(dec_pulse);
        end
        check("both_after_release", n_inc, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        check("both_repress", int'(inc_pulse), 1);
        step(0, 0, 0, 0, 0, 1);

        // ---- inactivity timeout ----
        phase = "timeout";
        first = -1;
        for (int k = 1; k <= T + 100 && first < 0; k++) begin
            step(0, 0, 0, 0, 1, 1);
            if (mode == 2'd0) first = k;
        end
        check("timeout_ticks", first, T);
        press_mode();
        check("timeout_reenter", int'(mode), 1);
        for (int k = 0; k < T - 1; k++) step(0, 0, 0, 0, 1, 1);
        check("timeout_9999", int'(mode), 1);
        step(0, 0, 1, 0, 1, 1);             // press with coincident tick
        check("timeout_press_inc", int'(inc_pulse), 1);
        step(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < T - 1; k++) step(0, 0, 0, 0, 1, 1);
        check("timeout_restart_hold", int'(mode), 1);
        step(0, 0, 0, 0, 1, 1);
        check("timeout_restart_fire", int'(mode), 0);

        // ---- blink in SET_MIN ----
        phase = "blink";
        press_mode(); press_mode();
        check("blink_mode", int'(mode), 2);
        for (int k = 1; k <= 1700; k++) begin
            step(0, 0, 0, 0, 1, 1);
            if (k == H - 1 || k == H || k == 2 * H || k == 3 * H || k == 1700)
                check($sformatf("blink_phase_%0d", k), int'(blink), (k / H) % 2);
        end
        step(0, 0, 1, 0, 0, 1);
        check("blink_inc", int'(inc_pulse), 1);
        check("blink_forced", int'(blink), 0);
        step(0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 600; k++) begin
            step(0, 0, 0, 0, 1, 1);
            if (k == H - 1) check("blink_after_inc_low", int'(blink), 0);
            if (k == H)     check("blink_after_inc_toggle", int'(blink), 1);
        end

        // ---- randomized run against the model ----
        phase = "random";
        ru = 0; rd = 0; rm = 0;
        for (int k = 0; k < 8000; k++) begin
            if ($urandom_range(0, 299) == 0) ru = ~ru;
            if ($urandom_range(0, 299) == 0) rd = ~rd;
            if ($urandom_range(0, 499) == 0) rm = ~rm;
            step($urandom_range(0, 2999) == 0, rm, ru, rd,
                 $urandom_range(0, 3) != 0, 1);
            if (inc_pulse && dec_pulse) check("random_exclusive", 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
